instr_fetch_unit: RTL and testbench

- Upstream neighbour of the multi-cycle control FSM: holds the PC and instruction register (IR), fetches from instruction memory over a req/ack handshake, and decodes IR fields.
- Supplies opcode (5 bits) to the control FSM.
- Applies the control FSM's PCWrite/PCSrc to update the PC (sequential increment or jump target).

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/pc_reg.sv | 24 ++
 rtl/instr_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, IR field positions and fetch state encoding.
package cpu_pkg;

  localparam logic [4:0] OP_JUMP = 5'b01010;
  localparam logic [4:0] OP_JAL  = 5'b01011;
  localparam logic [4:0] OP_LD   = 5'b01100;
  localparam logic [4:0] OP_ST   = 5'b01101;
  localparam logic [4:0] OP_PUSH = 5'b01110;
  localparam logic [4:0] OP_POP  = 5'b01111;

  // IR field layout; the opcode sits in the top OPC_W bits of the IR.
  localparam int unsigned OPC_W   = 5;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_LSB = 5;
  localparam int unsigned RS2_LSB = 2;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned IMM_W   = 8;

  // Fetch FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/pc_reg.sv
// Program counter: sequential increment or jump, plus PC+1 link value.
module pc_reg #(
  parameter int unsigned         ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_write,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_link
);

  // Increment wraps naturally at the register width.
  assign pc_link = pc + ADDR_W'(1);

  // PC update from the control FSM's PCWrite/PCSrc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        pc <= RESET_PC;
    else if (pc_write) pc <= pc_src ? jump_target : pc_link;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, IR, req/ack fetch FSM and IR field decode.
// Optional ack watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       INSTR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic               flush,
  input  logic               pc_write,
  input  logic               pc_src,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic               busy,
  output logic [INSTR_W-1:0] ir,
  output logic [4:0]         opcode,
  output logic [2:0]         rd,
  output logic [2:0]         rs1,
  output logic [2:0]         rs2,
  output logic [7:0]         imm8,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_link,
  output logic               fetch_err
);

  // The watchdog counter is 4 bits wide.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 15) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..15");
  end

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [INSTR_W-1:0] ir_q;
  logic               valid_q;
  logic               load_ir;
  logic               tmo_hit;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .reset       (reset),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .jump_target (jump_target),
    .pc          (pc),
    .pc_link     (pc_link)
  );

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] tmo_cnt_q;
  logic       err_q;

  assign tmo_hit   = (state_q == ST_WAIT || state_q == ST_DRAIN) && !imem_ack &&
                     (tmo_cnt_q == 4'(TIMEOUT_CYC - 1));
  assign fetch_err = err_q;

  // Count cycles spent in WAIT/DRAIN; any state change restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    tmo_cnt_q <= '0;
    else if (state_d != state_q)   tmo_cnt_q <= '0;
    else if (state_q == ST_WAIT || state_q == ST_DRAIN)
                                   tmo_cnt_q <= tmo_cnt_q + 4'd1;
    else                           tmo_cnt_q <= '0;
  end

  // Sticky watchdog error, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       err_q <= 1'b0;
    else if (tmo_hit) err_q <= 1'b1;
  end
`else
  assign tmo_hit   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // Next-state logic; an ack coinciding with flush is consumed but discarded.
  always_comb begin
    state_d = state_q;
    load_ir = 1'b0;
    case (state_q)
      ST_IDLE: if (fetch_req) state_d = ST_REQ;
      ST_REQ, ST_WAIT: begin
        if (imem_ack) begin
          state_d = ST_IDLE;
          load_ir = !flush;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: if (imem_ack || tmo_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register and fetch address capture (old PC wins on same-cycle update).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && fetch_req) addr_q <= pc;
    end
  end

  // Instruction register and its registered valid pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= load_ir;
      if (load_ir) ir_q <= imem_rdata;
    end
  end

  assign imem_req    = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign imem_addr   = addr_q;
  assign busy        = (state_q != ST_IDLE);
  assign instr_valid = valid_q;
  assign ir          = ir_q;
  assign opcode      = ir_q[INSTR_W-1 -: OPC_W];
  assign rd          = ir_q[RD_LSB  +: REG_W];
  assign rs1         = ir_q[RS1_LSB +: REG_W];
  assign rs2         = ir_q[RS2_LSB +: REG_W];
  assign imm8        = ir_q[IMM_LSB +: IMM_W];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit (default parameters).
module tb_instr_fetch_unit;

  localparam int TIMEOUT_CYC = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, flush, pc_write, pc_src;
  logic [15:0] jump_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid, busy;
  logic [15:0] ir;
  logic [4:0]  opcode;
  logic [2:0]  rd, rs1, rs2;
  logic [7:0]  imm8;
  logic [15:0] pc, pc_link;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;
  int model_pc = 0;   // reference PC as a plain integer, modulo 65536

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .flush(flush),
    .pc_write(pc_write), .pc_src(pc_src), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .busy(busy),
    .ir(ir), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm8(imm8),
    .pc(pc), .pc_link(pc_link), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1);
  end

  // Memory-side driver for one fetch; observations are returned for checking.
  task automatic fetch_txn(input int waits, input logic [15:0] data, input bit pulse_in_wait,
                           input bit jump_same, input logic [15:0] jt,
                           output int req_cyc, output logic [15:0] addr_seen, output bit addr_stable,
                           output int valid_cnt, output int valid_lat, output bit timed_out);
    int cyc;
    int ack_cyc;
    req_cyc = 0; addr_seen = '0; addr_stable = 1; valid_cnt = 0; valid_lat = -1;
    timed_out = 0; ack_cyc = -1;
    fetch_req = 1'b1;
    if (jump_same) begin pc_write = 1'b1; pc_src = 1'b1; jump_target = jt; end
    @(negedge clk);
    fetch_req = 1'b0; pc_write = 1'b0; pc_src = 1'b0;
    cyc = 1;
    while (ack_cyc < 0 || cyc <= ack_cyc + 3) begin
      if (cyc > 60) begin timed_out = 1; break; end
      if (instr_valid) begin valid_cnt++; if (valid_lat < 0) valid_lat = cyc; end
      if (imem_req) begin
        req_cyc++;
        if (req_cyc == 1) addr_seen = imem_addr;
        else if (imem_addr !== addr_seen) addr_stable = 0;
      end
      imem_ack = 1'b0;
      imem_rdata = 16'($urandom);
      if (imem_req && req_cyc == waits + 1) begin
        imem_ack = 1'b1; imem_rdata = data; ack_cyc = cyc;
      end
      fetch_req = pulse_in_wait && imem_req && (req_cyc == 2);
      @(negedge clk);
      cyc++;
    end
    imem_ack = 1'b0; fetch_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; fetch_req = 0; flush = 0; pc_write = 0; pc_src = 0;
    jump_target = '0; imem_ack = 0; imem_rdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 16'h0000); end
    checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir got %h want %h", ir, 16'h0000); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", fetch_err); end
    checks++; if (pc_link !== 16'h0001) begin errors++; $display("FAIL reset_link got %h want 0001", pc_link); end
    reset = 1'b1;
    model_pc = 0;
    @(negedge clk);
  endtask

  task automatic test_zero_wait();
    int rc, vc, vl; logic [15:0] a; bit st, to;
    fetch_txn(0, 16'h6123, 0, 0, 16'h0, rc, a, st, vc, vl, to);
    checks++; if (to) begin errors++; $display("FAIL zw_timeout got stuck want done"); end
    checks++; if (a !== 16'(model_pc)) begin errors++; $display("FAIL zw_addr got %h want %h", a, 16'(model_pc)); end
    checks++; if (rc !== 1) begin errors++; $display("FAIL zw_req_cycles got %0d want 1", rc); end
    checks++; if (vc !== 1) begin errors++; $display("FAIL zw_valid_count got %0d want 1", vc); end
    checks++; if (vl !== 2) begin errors++; $display("FAIL zw_latency got %0d want 2", vl); end
    checks++; if (ir !== 16'h6123) begin errors++; $display("FAIL zw_ir got %h want 6123", ir); end
    checks++; if (opcode !== 5'b01100) begin errors++; $display("FAIL zw_opcode got %b want 01100", opcode); end
    checks++; if (rd !== 3'd1) begin errors++; $display("FAIL zw_rd got %0d want 1", rd); end
    checks++; if (rs1 !== 3'd1) begin errors++; $display("FAIL zw_rs1 got %0d want 1", rs1); end
    checks++; if (rs2 !== 3'd0) begin errors++; $display("FAIL zw_rs2 got %0d want 0", rs2); end
    checks++; if (imm8 !== 8'h23) begin errors++; $display("FAIL zw_imm8 got %h want 23", imm8); end
  endtask

  task automatic test_wait_states();
    int rc, vc, vl; logic [15:0] a, d; bit st, to;
    d = 16'($urandom);
    fetch_txn(3, d, 1, 0, 16'h0, rc, a, st, vc, vl, to);
    checks++; if (to) begin errors++; $display("FAIL ws_timeout got stuck want done"); end
    checks++; if (rc !== 4) begin errors++; $display("FAIL ws_req_cycles got %0d want 4", rc); end
    checks++; if (!st) begin errors++; $display("FAIL ws_addr_stable got unstable want stable"); end
    checks++; if (a !== 16'(model_pc)) begin errors++; $display("FAIL ws_addr got %h want %h", a, 16'(model_pc)); end
    checks++; if (vc !== 1) begin errors++; $display("FAIL ws_valid_count got %0d want 1", vc); end
    checks++; if (vl !== 5) begin errors++; $display("FAIL ws_latency got %0d want 5", vl); end
    checks++; if (ir !== d) begin errors++; $display("FAIL ws_ir got %h want %h", ir, d); end
    checks++; if (busy !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL ws_no_queue got busy=%b req=%b want 0 0", busy, imem_req); end
  endtask

  task automatic test_pc_wrap();
    pc_write = 1; pc_src = 1; jump_target = 16'hFFFF;
    @(negedge clk);
    checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_set got %h want FFFF", pc); end
    checks++; if (pc_link !== 16'h0000) begin errors++; $display("FAIL wrap_link_ffff got %h want 0000", pc_link); end
    pc_src = 0;
    @(negedge clk);
    pc_write = 0;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h want 0000", pc); end
    checks++; if (pc_link !== 16'h0001) begin errors++; $display("FAIL wrap_link got %h want 0001", pc_link); end
    model_pc = 0;
  endtask

  task automatic test_jump_with_fetch();
    int rc, vc, vl; logic [15:0] a; bit st, to;
    pc_write = 1; pc_src = 1; jump_target = 16'h0123;
    @(negedge clk);
    pc_write = 0; pc_src = 0;
    model_pc = 16'h0123;
    fetch_txn(0, 16'h5A5A, 0, 1, 16'h0040, rc, a, st, vc, vl, to);
    checks++; if (a !== 16'h0123) begin errors++; $display("FAIL jf_old_addr got %h want 0123", a); end
    checks++; if (pc !== 16'h0040) begin errors++; $display("FAIL jf_pc got %h want 0040", pc); end
    model_pc = 16'h0040;
    fetch_txn(1, 16'h1357, 0, 0, 16'h0, rc, a, st, vc, vl, to);
    checks++; if (a !== 16'h0040) begin errors++; $display("FAIL jf_new_addr got %h want 0040", a); end
    checks++; if (ir !== 16'h1357 || vc !== 1) begin errors++; $display("FAIL jf_second got ir=%h vc=%0d want 1357 1", ir, vc); end
  endtask

  task automatic test_flush();
    logic [15:0] ir_before; int vseen;
    ir_before = ir; vseen = 0;
    fetch_req = 1; @(negedge clk);          // REQ
    fetch_req = 0; @(negedge clk);          // WAIT
    flush = 1;     @(negedge clk);          // DRAIN
    flush = 0;
    if (instr_valid) vseen++;
    checks++; if (imem_req !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fl_drain got req=%b busy=%b want 0 1", imem_req, busy); end
    @(negedge clk);
    if (instr_valid) vseen++;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fl_busy_hold got %b want 1", busy); end
    imem_ack = 1; imem_rdata = 16'hBEEF;
    @(negedge clk);
    imem_ack = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fl_busy_fall got %b want 0", busy); end
    repeat (3) begin if (instr_valid) vseen++; @(negedge clk); end
    checks++; if (vseen !== 0) begin errors++; $display("FAIL fl_no_valid got %0d want 0", vseen); end
    checks++; if (ir !== ir_before) begin errors++; $display("FAIL fl_ir got %h want %h", ir, ir_before); end
  endtask

  task automatic test_flush_ack();
    logic [15:0] ir_before; int vseen;
    ir_before = ir; vseen = 0;
    fetch_req = 1; @(negedge clk);          // REQ
    fetch_req = 0; flush = 1; imem_ack = 1; imem_rdata = ~ir_before;
    @(negedge clk);
    flush = 0; imem_ack = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fa_busy got %b want 0", busy); end
    repeat (3) begin if (instr_valid) vseen++; @(negedge clk); end
    checks++; if (vseen !== 0 || ir !== ir_before) begin errors++; $display("FAIL fa_discard got vc=%0d ir=%h want 0 %h", vseen, ir, ir_before); end
    flush = 1; @(negedge clk); flush = 0;   // flush while idle
    checks++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL fa_idle_flush got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_fetch();
    fetch_req = 1; @(negedge clk);
    fetch_req = 0; @(negedge clk);          // WAIT
    #2 reset = 0;
    #1;
    checks++; if (busy !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rm_async got busy=%b req=%b want 0 0", busy, imem_req); end
    checks++; if (ir !== 16'h0 || pc !== 16'h0) begin errors++; $display("FAIL rm_regs got ir=%h pc=%h want 0000 0000", ir, pc); end
    @(negedge clk);
    reset = 1; model_pc = 0;
    imem_ack = 1; imem_rdata = 16'hCAFE;
    @(negedge clk);
    imem_ack = 0;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0 || ir !== 16'h0 || busy !== 1'b0) begin errors++; $display("FAIL rm_late_ack got v=%b ir=%h busy=%b want 0 0000 0", instr_valid, ir, busy); end
  endtask

  task automatic test_random();
    int rc, vc, vl, op, w; logic [15:0] a, d, jt; bit st, to;
    for (int i = 0; i < 24; i++) begin
      op = int'($urandom_range(0, 2));
      if (op != 0) begin
        jt = 16'($urandom);
        pc_write = 1; pc_src = (op == 2); jump_target = jt;
        @(negedge clk);
        pc_write = 0; pc_src = 0;
        if (op == 2) model_pc = int'(jt); else model_pc = (model_pc + 1) % 65536;
      end
      checks++; if (pc !== 16'(model_pc) || pc_link !== 16'((model_pc + 1) % 65536)) begin errors++; $display("FAIL rnd_pc[%0d] got %h/%h want %h", i, pc, pc_link, 16'(model_pc)); end
      w = int'($urandom_range(0, 4));
      d = 16'($urandom);
      fetch_txn(w, d, 0, 0, 16'h0, rc, a, st, vc, vl, to);
      checks++; if (to || a !== 16'(model_pc) || !st) begin errors++; $display("FAIL rnd_addr[%0d] got %h want %h", i, a, 16'(model_pc)); end
      checks++; if (vc !== 1 || vl !== w + 2) begin errors++; $display("FAIL rnd_valid[%0d] got cnt=%0d lat=%0d want 1 %0d", i, vc, vl, w + 2); end
      checks++; if (ir !== d) begin errors++; $display("FAIL rnd_ir[%0d] got %h want %h", i, ir, d); end
      checks++; if (opcode !== 5'(d / 2048) || rd !== 3'((d / 256) % 8) || rs1 !== 3'((d / 32) % 8) ||
                    rs2 !== 3'((d / 4) % 8) || imm8 !== 8'(d % 256)) begin
        errors++; $display("FAIL rnd_fields[%0d] got %b %0d %0d %0d %h for ir %h", i, opcode, rd, rs1, rs2, imm8, d);
      end
    end
  endtask

  task automatic test_timeout();
    int cyc; int vseen; bit seen;
`ifdef FETCH_TIMEOUT_EN
    vseen = 0; seen = 0; cyc = 0;
    fetch_req = 1; @(negedge clk); fetch_req = 0; cyc = 1;
    while (cyc < 40) begin
      if (instr_valid) vseen++;
      if (fetch_err) begin seen = 1; break; end
      @(negedge clk); cyc++;
    end
    checks++; if (!seen) begin errors++; $display("FAIL to_err got 0 want 1"); end
    checks++; if (cyc < TIMEOUT_CYC + 1 || cyc > TIMEOUT_CYC + 3) begin errors++; $display("FAIL to_cycles got %0d want about %0d", cyc, TIMEOUT_CYC + 2); end
    checks++; if (imem_req !== 1'b0 || busy !== 1'b0 || vseen !== 0) begin errors++; $display("FAIL to_state got req=%b busy=%b v=%0d want 0 0 0", imem_req, busy, vseen); end
    @(negedge clk);
    checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", fetch_err); end
    reset = 0; @(negedge clk); reset = 1; model_pc = 0;
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL to_clear got %b want 0", fetch_err); end
`else
    vseen = 0; seen = 0;
    fetch_req = 1; @(negedge clk); fetch_req = 0;
    for (cyc = 0; cyc < 30; cyc++) begin
      if (fetch_err) seen = 1;
      @(negedge clk);
    end
    checks++; if (busy !== 1'b1 || imem_req !== 1'b1 || seen) begin errors++; $display("FAIL nt_wait got busy=%b req=%b err=%b want 1 1 0", busy, imem_req, seen); end
    imem_ack = 1; imem_rdata = 16'h0A0B;
    @(negedge clk);
    imem_ack = 0;
    if (instr_valid) vseen++;
    checks++; if (vseen !== 1 || ir !== 16'h0A0B) begin errors++; $display("FAIL nt_late_ack got v=%0d ir=%h want 1 0a0b", vseen, ir); end
`endif
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_pc_wrap();
    test_jump_with_fetch();
    test_flush();
    test_flush_ack();
    test_reset_mid_fetch();
    test_random();
    test_timeout();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
